wired_rob_commit: RTL and testbench
===================================

Name: wired_rob_commit

Overview:
- Commit-side reader/retirer for the ROB; the consumer end of the ROB commit read port.
- Owns the ROB head pointer and drives the two commit read ids each cycle.
- Inspects the returned entries and decides how many retire (0/1/2), producing ARF writes, store-buffer commits and redirects.
- On a redirect it drives the ROB flush and drains every remaining entry, so the rename state is restored by retirement.

Parameters:
- ROB_LEN, 6, log2 of ROB depth; width of rob_rid_t.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- c_rrrid_o  out  2xROB_LEN  commit read ids: [0]=head, [1]=head+1 mod 2^ROB_LEN.
- c_rob_valid_i  in  2  entry valid per slot, returned the same cycle as c_rrrid_o.
- c_rob_entry_i  in  2x$bits(rob_entry_t)  entry contents per slot, same cycle.
- c_retire_o  out  2  retire per slot; slot1 is never set without slot0.
- flush_o  out  1  ROB flush; high throughout DRAIN.
- stall_o  out  1  dispatch stall; high throughout DRAIN.
- arf_we_o  out  2  ARF write enable.
- arf_waddr_o  out  2x5  ARF write address (entry wreg).
- arf_wdata_o  out  2x32  ARF write data (entry wdata).
- sb_commit_o  out  1  commit the oldest store-buffer entry.
- sb_ready_i  in  1  store buffer can accept a commit this cycle.
- excp_entry_i  in  32  exception vector (from CSR).
- redirect_o  out  1  one-cycle frontend redirect pulse.
- redirect_pc_o  out  32  redirect target.
- retired_cnt_o  out  32  retired-instruction counter; excludes drained entries; wraps.

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low. On reset: head=0, state RUN, retired_cnt=0, c_rrrid_o={1,0}, all other outputs 0.
- Timing:
  - ROB read is combinational from the registered c_rrrid_o.
  - All retire decisions are combinational within the same cycle.
  - head advances at posedge by popcount(c_retire_o), wrapping mod 2^ROB_LEN.
- Slot redirect condition (redir[i]): static_excp or lsu_excp valid, or need_jump, or uncached.
- RUN, slot0 retires when all hold:
  - c_rob_valid_i[0];
  - if store_buffer, then sb_ready_i.
- RUN, slot1 retires when all hold:
  - slot0 retires;
  - ~redir[0];
  - c_rob_valid_i[1];
  - not (store_buffer on both slots), i.e. at most one store per cycle;
  - if slot1 is a store, then sb_ready_i.
- ARF write: arf_we_o[i] = retire[i] & ~excp[i] & (wreg!=0).
- sb_commit_o = OR over slots of (retire[i] & store_buffer[i] & ~excp[i]).
- Redirect source: the lowest retiring slot with redir.
  - redirect_o is asserted that cycle; next state is DRAIN.
  - redirect_pc_o selection: exception → excp_entry_i; need_jump → target_addr; uncached → pc+4.
  - Priority among these: exception > need_jump > uncached.
- DRAIN:
  - flush_o=1, stall_o=1.
  - c_retire_o=c_rob_valid_i; no ARF writes, no sb_commit, no redirect.
  - retired_cnt is not incremented.
  - Exits to RUN in the cycle after c_rob_valid_i==0 is observed. head is left unchanged (it equals the tail).
- Boundaries:
  - Empty ROB (valid=00): no retire, head holds.
  - Head wrap: ids 2^ROB_LEN-1 and 0 are valid as a pair.
  - Redirect in slot1: slot0 commits normally, then DRAIN.
  - A store in slot0 with ~sb_ready_i blocks both slots.
  - Reset asserted mid-DRAIN returns to RUN with head=0.

Optional Feature:
- WIRED_COMMIT_DUAL_EN defined: dual retire as above.
- Undefined:
  - slot1 never retires in RUN; c_retire_o[1], arf_we_o[1] tied 0 in RUN.
  - DRAIN still retires both slots.
  - c_rrrid_o[1] is still driven.

Decomposition:
- Shared package gets:
  - commit_state_e {RUN, DRAIN};
  - redirect-cause enum {EXCP, JUMP, UNCACHED};
  - rob_rid_t and rob_entry_t are reused from it.
- Sub-module wired_commit_slot_check (one per slot, combinational): computes redir, redirect cause, target, store and arf_we from one entry.

Test Plan:
- Reset → c_rrrid_o={1,0}, c_retire_o=0, flush_o=0, retired_cnt_o=0.
- Two valid ALU entries (wreg 3,5; wdata 0x11,0x22) at head 0 → c_retire_o=11, arf_we_o=11, waddr 3/5, head=2, cnt=2.
- Stores in both slots, sb_ready_i=1 → cycle 1 retire=01 with sb_commit; cycle 2 slot0 = second store, retire resumes.
- Slot0 need_jump target 0x1C000100, 3 more valid entries → retire=01, redirect_o pulse with pc 0x1C000100; DRAIN for 2 cycles (retire 11 then 01) plus exit cycle; cnt +1 only.
- Slot1 lsu_excp, excp_entry_i=0x1C008000 → retire=11, arf_we_o=01, redirect pc 0x1C008000, then DRAIN.
- Head at 63 (ROB_LEN=6), 2 valid → c_rrrid_o={0,63}, head wraps to 1.

Source files
------------

// File: rtl/wired_rob_commit_pkg.sv
// Shared types for the ROB commit stage: ROB entry layout, commit FSM states,
// redirect causes and a small popcount helper.
package wired_rob_commit_pkg;

    localparam int ROB_LEN_DEF = 6;

    typedef logic [ROB_LEN_DEF-1:0] rob_rid_t;

    typedef enum logic {RUN, DRAIN} commit_state_e;

    typedef enum logic [1:0] {EXCP, JUMP, UNCACHED} redir_cause_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        static_excp;
        logic        lsu_excp;
        logic        need_jump;
        logic [31:0] target_addr;
        logic        uncached;
        logic        store_buffer;
    } rob_entry_t;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/wired_rob_commit_slot_check.sv
// Per-slot commit inspection: decides whether the entry redirects, where to,
// and what ARF write / store-buffer commit it produces once it retires.
module wired_commit_slot_check
    import wired_rob_commit_pkg::*;
(
    input  rob_entry_t  entry_i,
    input  logic [31:0] excp_entry_i,
    input  logic        commit_i,
    output logic        redir_o,
    output logic [31:0] target_o,
    output logic        store_o,
    output logic        arf_we_o,
    output logic [4:0]  arf_waddr_o,
    output logic [31:0] arf_wdata_o,
    output logic        sb_commit_o
);

    logic         excp;
    redir_cause_e cause;

    always_comb begin
        excp     = entry_i.static_excp | entry_i.lsu_excp;
        redir_o  = excp | entry_i.need_jump | entry_i.uncached;
        store_o  = entry_i.store_buffer;
        // Exception outranks a taken jump, which outranks an uncached refetch.
        if (excp)                   cause = EXCP;
        else if (entry_i.need_jump) cause = JUMP;
        else                        cause = UNCACHED;
        case (cause)
            EXCP:    target_o = excp_entry_i;
            JUMP:    target_o = entry_i.target_addr;
            default: target_o = entry_i.pc + 32'd4;
        endcase
        arf_we_o    = commit_i & ~excp & (entry_i.wreg != 5'd0);
        arf_waddr_o = entry_i.wreg;
        arf_wdata_o = entry_i.wdata;
        sb_commit_o = commit_i & entry_i.store_buffer & ~excp;
    end

endmodule

// File: rtl/wired_rob_commit.sv
// ROB commit reader/retirer: owns the head pointer, retires up to two entries
// per cycle and drains the ROB after a redirect. WIRED_COMMIT_DUAL_EN enables slot1 in RUN.
module wired_rob_commit
    import wired_rob_commit_pkg::*;
#(
    parameter int ROB_LEN = ROB_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [1:0][ROB_LEN-1:0] c_rrrid_o,
    input  logic [1:0]             c_rob_valid_i,
    input  rob_entry_t [1:0]       c_rob_entry_i,
    output logic [1:0]             c_retire_o,
    output logic                   flush_o,
    output logic                   stall_o,
    output logic [1:0]             arf_we_o,
    output logic [1:0][4:0]        arf_waddr_o,
    output logic [1:0][31:0]       arf_wdata_o,
    output logic                   sb_commit_o,
    input  logic                   sb_ready_i,
    input  logic [31:0]            excp_entry_i,
    output logic                   redirect_o,
    output logic [31:0]            redirect_pc_o,
    output logic [31:0]            retired_cnt_o
);

`ifdef WIRED_COMMIT_DUAL_EN
    localparam bit DualEn = 1'b1;
`else
    localparam bit DualEn = 1'b0;
`endif

    commit_state_e    state_q, state_d;
    logic [ROB_LEN-1:0] head_q, head_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [1:0]       redir, store, commit, sb_vec;
    logic [1:0][31:0] target;
    logic             ok0, ok1;

    // Drained entries must not touch architectural state.
    assign commit = c_retire_o & {2{state_q == RUN}};

    for (genvar i = 0; i < 2; i++) begin : g_slot
        wired_commit_slot_check u_slot (
            .entry_i      (c_rob_entry_i[i]),
            .excp_entry_i (excp_entry_i),
            .commit_i     (commit[i]),
            .redir_o      (redir[i]),
            .target_o     (target[i]),
            .store_o      (store[i]),
            .arf_we_o     (arf_we_o[i]),
            .arf_waddr_o  (arf_waddr_o[i]),
            .arf_wdata_o  (arf_wdata_o[i]),
            .sb_commit_o  (sb_vec[i])
        );
    end

    assign c_rrrid_o[0]  = head_q;
    assign c_rrrid_o[1]  = head_q + ROB_LEN'(1);
    assign sb_commit_o   = |sb_vec;
    assign retired_cnt_o = cnt_q;

    always_comb begin
        c_retire_o    = '0;
        flush_o       = 1'b0;
        stall_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        ok0           = 1'b0;
        ok1           = 1'b0;
        case (state_q)
            RUN: begin
                ok0 = c_rob_valid_i[0] & (~store[0] | sb_ready_i);
                // At most one store per cycle; nothing younger than a redirect retires.
                ok1 = DualEn & ok0 & ~redir[0] & c_rob_valid_i[1]
                      & ~(store[0] & store[1]) & (~store[1] | sb_ready_i);
                c_retire_o = {ok1, ok0};
                cnt_d      = cnt_q + 32'(popcnt2(c_retire_o));
                if (ok0 & redir[0]) begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = target[0];
                    state_d       = DRAIN;
                end else if (ok1 & redir[1]) begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = target[1];
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                flush_o    = 1'b1;
                stall_o    = 1'b1;
                c_retire_o = c_rob_valid_i;
                if (c_rob_valid_i == 2'b00) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        head_d = head_q + ROB_LEN'(popcnt2(c_retire_o));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            head_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wired_rob_commit.sv
// Directed bench for wired_rob_commit: stimulus pushes expected responses into
// a queue, a negedge monitor pops and compares every presented cycle.
module tb_wired_rob_commit;
    import wired_rob_commit_pkg::*;

`ifdef WIRED_COMMIT_DUAL_EN
    localparam bit D = 1'b1;
`else
    localparam bit D = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0][5:0]  c_rrrid_o;
    logic [1:0]       c_rob_valid_i;
    rob_entry_t [1:0] c_rob_entry_i;
    logic [1:0]       c_retire_o;
    logic             flush_o, stall_o;
    logic [1:0]       arf_we_o;
    logic [1:0][4:0]  arf_waddr_o;
    logic [1:0][31:0] arf_wdata_o;
    logic             sb_commit_o;
    logic             sb_ready_i;
    logic [31:0]      excp_entry_i;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic [31:0]      retired_cnt_o;

    always #5 clk = ~clk;

    wired_rob_commit #(.ROB_LEN(6)) dut (
        .clk(clk), .rst_n(rst_n), .c_rrrid_o(c_rrrid_o),
        .c_rob_valid_i(c_rob_valid_i), .c_rob_entry_i(c_rob_entry_i),
        .c_retire_o(c_retire_o), .flush_o(flush_o), .stall_o(stall_o),
        .arf_we_o(arf_we_o), .arf_waddr_o(arf_waddr_o), .arf_wdata_o(arf_wdata_o),
        .sb_commit_o(sb_commit_o), .sb_ready_i(sb_ready_i),
        .excp_entry_i(excp_entry_i), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .retired_cnt_o(retired_cnt_o)
    );

    typedef struct {
        logic [1:0]  ret, we;
        logic        sb, rd, fl;
        logic [31:0] pc, cnt, wd0, wd1;
        logic [5:0]  hd;
        logic [4:0]  wa0, wa1;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0, n_fail = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
        n_tests++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", n, a, x, $time);
        end
    endfunction

    function automatic exp_t mk(logic [1:0] r, logic [1:0] w, logic s, logic d,
                                logic [31:0] p, logic f, logic [5:0] h, logic [31:0] c);
        exp_t x;
        x.ret = r; x.we = w; x.sb = s; x.rd = d; x.pc = p; x.fl = f; x.hd = h; x.cnt = c;
        x.wa0 = '0; x.wa1 = '0; x.wd0 = '0; x.wd1 = '0;
        return x;
    endfunction

    function automatic rob_entry_t ent(logic [31:0] pc, logic [4:0] wr, logic [31:0] wd);
        rob_entry_t e;
        e = '0; e.pc = pc; e.wreg = wr; e.wdata = wd;
        return e;
    endfunction

    task automatic step(logic [1:0] v, rob_entry_t e0, rob_entry_t e1, logic sbr, exp_t x);
        @(posedge clk); #1;
        c_rob_valid_i    = v;
        c_rob_entry_i[0] = e0;
        c_rob_entry_i[1] = e1;
        sb_ready_i       = sbr;
        x.wa0 = e0.wreg; x.wd0 = e0.wdata; x.wa1 = e1.wreg; x.wd1 = e1.wdata;
        sbq.push_back(x);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        c_rob_valid_i = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        logic [5:0] h1;
        if (sbq.size() != 0) begin
            e  = sbq.pop_front();
            h1 = e.hd + 6'd1;
            chk("retire", 32'(c_retire_o), 32'(e.ret));
            chk("arf_we", 32'(arf_we_o), 32'(e.we));
            chk("sb_commit", 32'(sb_commit_o), 32'(e.sb));
            chk("redirect", 32'(redirect_o), 32'(e.rd));
            chk("flush", 32'(flush_o), 32'(e.fl));
            chk("stall", 32'(stall_o), 32'(e.fl));
            chk("rrrid0", 32'(c_rrrid_o[0]), 32'(e.hd));
            chk("rrrid1", 32'(c_rrrid_o[1]), 32'(h1));
            chk("retired_cnt", retired_cnt_o, e.cnt);
            if (e.rd) chk("redirect_pc", redirect_pc_o, e.pc);
            if (e.we[0]) chk("waddr0", {arf_waddr_o[0], arf_wdata_o[0][26:0]}, {e.wa0, e.wd0[26:0]});
            if (e.we[1]) chk("waddr1", {arf_waddr_o[1], arf_wdata_o[1][26:0]}, {e.wa1, e.wd1[26:0]});
        end
    end

    initial begin
        rob_entry_t z, a, b, s0, s1, j, x, u;
        logic [5:0] hb;
        z = '0;
        c_rob_valid_i = '0; c_rob_entry_i = '0; sb_ready_i = 1'b1;
        excp_entry_i = 32'h1C008000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, 6'd0, 0));

        // ALU pair at head 0
        a = ent(32'h1C000000, 5'd3, 32'h11);
        b = ent(32'h1C000004, 5'd5, 32'h22);
        step(2'b11, a, b, 1'b1, mk(D ? 2'b11 : 2'b01, D ? 2'b11 : 2'b01, 0, 0, 0, 0, 6'd0, 0));
        hb = D ? 6'd2 : 6'd1;
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, hb, 32'(hb)));

        // stores: blocked when not ready, then one store per cycle
        s0 = ent(32'h1C000010, 5'd0, 32'h0); s0.store_buffer = 1'b1;
        s1 = ent(32'h1C000014, 5'd0, 32'h0); s1.store_buffer = 1'b1;
        b  = ent(32'h1C000018, 5'd6, 32'h66);
        step(2'b11, s0, b, 1'b0, mk(2'b00, 2'b00, 0, 0, 0, 0, hb, 32'(hb)));
        step(2'b11, s0, s1, 1'b1, mk(2'b01, 2'b00, 1, 0, 0, 0, hb, 32'(hb)));
        step(2'b11, s1, b, 1'b1, mk(D ? 2'b11 : 2'b01, D ? 2'b10 : 2'b00, 1, 0, 0, 0, hb + 6'd1, 32'(hb) + 1));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, hb + (D ? 6'd3 : 6'd2), 32'(hb) + (D ? 3 : 2)));

        // slot0 jump redirect then drain
        do_reset();
        j = ent(32'h1C000020, 5'd4, 32'h44); j.need_jump = 1'b1; j.target_addr = 32'h1C000100;
        step(2'b11, j, a, 1'b1, mk(2'b01, 2'b01, 0, 1, 32'h1C000100, 0, 6'd0, 0));
        step(2'b11, a, a, 1'b1, mk(2'b11, 2'b00, 0, 0, 0, 1, 6'd1, 1));
        step(2'b01, a, z, 1'b1, mk(2'b01, 2'b00, 0, 0, 0, 1, 6'd3, 1));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 1, 6'd4, 1));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, 6'd4, 1));

        // slot1 lsu exception
        do_reset();
        a = ent(32'h1C000030, 5'd7, 32'h77);
        x = ent(32'h1C000034, 5'd9, 32'h99); x.lsu_excp = 1'b1;
        step(2'b11, a, x, 1'b1, mk(D ? 2'b11 : 2'b01, 2'b01, 0, D, 32'h1C008000, 0, 6'd0, 0));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, D, D ? 6'd2 : 6'd1, D ? 2 : 1));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, D ? 6'd2 : 6'd1, D ? 2 : 1));

        // uncached refetch goes to pc+4
        do_reset();
        u = ent(32'h1C000200, 5'd8, 32'h88); u.uncached = 1'b1;
        step(2'b01, u, z, 1'b1, mk(2'b01, 2'b01, 0, 1, 32'h1C000204, 0, 6'd0, 0));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 1, 6'd1, 1));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, 6'd1, 1));

        // exception beats jump, no ARF write; reset lands mid-drain
        do_reset();
        x = ent(32'h1C000300, 5'd6, 32'h60); x.static_excp = 1'b1;
        x.need_jump = 1'b1; x.target_addr = 32'h1C000400;
        step(2'b01, x, z, 1'b1, mk(2'b01, 2'b00, 0, 1, 32'h1C008000, 0, 6'd0, 0));
        step(2'b11, a, a, 1'b1, mk(2'b11, 2'b00, 0, 0, 0, 1, 6'd1, 1));
        do_reset();
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, 6'd0, 0));

        // walk head to 63, then retire across the wrap
        for (int i = 0; i < 63; i++) begin
            a = ent(32'h1C001000, 5'd1, 32'(i));
            step(2'b01, a, z, 1'b1, mk(2'b01, 2'b01, 0, 0, 0, 0, 6'(i), 32'(i)));
        end
        a = ent(32'h1C002000, 5'd2, 32'hAA);
        b = ent(32'h1C002004, 5'd3, 32'hBB);
        step(2'b11, a, b, 1'b1, mk(D ? 2'b11 : 2'b01, D ? 2'b11 : 2'b01, 0, 0, 0, 0, 6'd63, 63));
        step(2'b00, z, z, 1'b1, mk(2'b00, 2'b00, 0, 0, 0, 0, D ? 6'd1 : 6'd0, D ? 65 : 64));

        @(posedge clk);
        @(posedge clk);
        if (sbq.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_queue: got %0d want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
